// File: rtl/neuro_bus_pkg.sv
// neuro_bus_pkg
// Shared definitions for the NeuroSpider host sequencer: engine register
// addresses, CacheSelect encodings, sequencer state and error-cause enums,
// and the header-word to register-address map.
package neuro_bus_pkg;

  // Engine configuration registers
  localparam logic [15:0] REG_IN_OFF  = 16'h8000;
  localparam logic [15:0] REG_IDX_OFF = 16'h8001;
  localparam logic [15:0] REG_WT_OFF  = 16'h8002;
  localparam logic [15:0] REG_NUM_OPS = 16'h8003;
  localparam logic [15:0] REG_DEST    = 16'h8004;
  localparam logic [15:0] REG_ACT_SEL = 16'h8005;

  // CacheSelect encodings
  localparam logic [1:0] SEL_INPUT  = 2'b00;
  localparam logic [1:0] SEL_INDEX  = 2'b01;
  localparam logic [1:0] SEL_WEIGHT = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR     = 4'd1,
    ST_LD_IN   = 4'd2,
    ST_LD_IDX  = 4'd3,
    ST_LD_WT   = 4'd4,
    ST_DRAIN   = 4'd5,
    ST_START   = 4'd6,
    ST_WAIT_LO = 4'd7,
    ST_WAIT_HI = 4'd8,
    ST_READ    = 4'd9,
    ST_RESULT  = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LENGTH  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_t;

  // Header words arrive as in_off, idx_off, wt_off, dest, num_ops, act_sel;
  // note dest and num_ops land on swapped register addresses.
  function automatic logic [15:0] hdr_reg_addr(input logic [2:0] k);
    logic [15:0] a;
    case (k)
      3'd0:    a = REG_IN_OFF;
      3'd1:    a = REG_IDX_OFF;
      3'd2:    a = REG_WT_OFF;
      3'd3:    a = REG_DEST;
      3'd4:    a = REG_NUM_OPS;
      default: a = REG_ACT_SEL;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/neuro_bus_writer.sv
// neuro_bus_writer
// Output register stage for the NeuroSpider bus. A beat presented on
// beat_valid is captured on the next clock edge; WE drops when no beat is
// presented while Address/InputData/CacheSelect hold their last value.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   beat_valid, beat_we            load a beat / write enable of that beat
//   beat_addr, beat_data, beat_sel beat contents
//   Address, InputData, CacheSelect, WE  registered bus outputs
module neuro_bus_writer
  import neuro_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        beat_valid,
  input  logic        beat_we,
  input  logic [15:0] beat_addr,
  input  logic [15:0] beat_data,
  input  logic [1:0]  beat_sel,
  output logic [15:0] Address,
  output logic [15:0] InputData,
  output logic [1:0]  CacheSelect,
  output logic        WE
);

  // Bus output register: one beat per cycle, WE never left high unrequested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Address     <= 16'h0000;
      InputData   <= 16'h0000;
      CacheSelect <= SEL_INPUT;
      WE          <= 1'b0;
    end else if (beat_valid) begin
      Address     <= beat_addr;
      InputData   <= beat_data;
      CacheSelect <= beat_sel;
      WE          <= beat_we;
    end else begin
      WE          <= 1'b0;
    end
  end

endmodule

// File: rtl/neuro_host_sequencer.sv
// neuro_host_sequencer
// Host-side initiator for the NeuroSpider bus. Consumes a 16-bit command
// stream (6 header words, then num_ops input, index and weight words),
// issues register writes and cache loads, pulses StartOperation, waits for
// the engine to finish and returns the word at the destination address.
// Ports:
//   cmd_valid/cmd_ready/cmd_data   command stream in
//   res_valid/res_ready/res_data   result word out
//   err, err_code                  sticky error flag and first cause
//   InputData, Address, CacheSelect, WE, StartOperation   bus out
//   ReadyForNextOp, OutputData     bus in
module neuro_host_sequencer
  import neuro_bus_pkg::*;
#(
  parameter int MAX_OPS  = 256,
  parameter int READ_LAT = 1,
  parameter int TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] InputData,
  output logic [15:0] Address,
  output logic [1:0]  CacheSelect,
  output logic        WE,
  output logic        StartOperation,
  input  logic        ReadyForNextOp,
  input  logic [15:0] OutputData
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int RD_W  = $clog2(READ_LAT + 2);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [RD_W-1:0]  RD_LAST   = RD_W'(READ_LAT + 1);
  localparam logic [15:0]      MAX_OPS_W = 16'(MAX_OPS);

  state_t      state_r;
  logic        cmd_ready_r;
  logic        res_valid_r;
  logic [15:0] res_data_r;
  logic        err_r;
  err_code_t   err_code_r;
  logic        start_r;
  logic [2:0]  hdr_cnt_r;
  logic [15:0] in_off_r, idx_off_r, wt_off_r, dest_r, num_ops_r;
  logic [15:0] idx_r;
  logic [17:0] drain_r;
  logic [TMO_W-1:0] tmo_r;
  logic [RD_W-1:0]  rd_cnt_r;

  logic        accept_s;
  logic        beat_valid_s, beat_we_s;
  logic [15:0] beat_addr_s, beat_data_s;
  logic [1:0]  beat_sel_s;

  assign accept_s = cmd_valid && cmd_ready_r;

  // Beat for the write stage: accepted words become writes, READ drives dest
  always_comb begin
    beat_valid_s = 1'b0;
    beat_we_s    = 1'b0;
    beat_addr_s  = 16'h0000;
    beat_data_s  = cmd_data;
    beat_sel_s   = SEL_INPUT;
    case (state_r)
      ST_HDR: begin
        if (accept_s) begin
          beat_valid_s = 1'b1;
          beat_we_s    = 1'b1;
          beat_addr_s  = hdr_reg_addr(hdr_cnt_r);
        end else begin
          beat_valid_s = 1'b0;
        end
      end
      ST_LD_IN, ST_LD_IDX, ST_LD_WT: begin
        if (accept_s) begin
          beat_valid_s = 1'b1;
          beat_we_s    = 1'b1;
          if (state_r == ST_LD_IN) begin
            beat_addr_s = in_off_r + idx_r;
            beat_sel_s  = SEL_INPUT;
          end else if (state_r == ST_LD_IDX) begin
            beat_addr_s = idx_off_r + idx_r;
            beat_sel_s  = SEL_INDEX;
          end else begin
            beat_addr_s = wt_off_r + idx_r;
            beat_sel_s  = SEL_WEIGHT;
          end
        end else begin
          beat_valid_s = 1'b0;
        end
      end
      ST_READ: begin
        beat_valid_s = 1'b1;
        beat_we_s    = 1'b0;
        beat_addr_s  = dest_r;
        beat_data_s  = 16'h0000;
        beat_sel_s   = SEL_INPUT;
      end
      default: begin
        beat_valid_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered handshake, result and error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      res_valid_r <= 1'b0;
      res_data_r  <= 16'h0000;
      err_r       <= 1'b0;
      err_code_r  <= ERR_NONE;
      start_r     <= 1'b0;
      hdr_cnt_r   <= 3'd0;
      in_off_r    <= 16'h0000;
      idx_off_r   <= 16'h0000;
      wt_off_r    <= 16'h0000;
      dest_r      <= 16'h0000;
      num_ops_r   <= 16'h0000;
      idx_r       <= 16'h0000;
      drain_r     <= 18'd0;
      tmo_r       <= '0;
      rd_cnt_r    <= '0;
    end else begin
      // START is a one-cycle state, so the pulse is exactly one cycle wide
      // and lands after the final cache write has left the bus register.
      start_r <= (state_r == ST_START);
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_r     <= ST_HDR;
            cmd_ready_r <= 1'b1;
            hdr_cnt_r   <= 3'd0;
          end
        end
        ST_HDR: begin
          if (accept_s) begin
            case (hdr_cnt_r)
              3'd0:    in_off_r  <= cmd_data;
              3'd1:    idx_off_r <= cmd_data;
              3'd2:    wt_off_r  <= cmd_data;
              3'd3:    dest_r    <= cmd_data;
              3'd4:    num_ops_r <= cmd_data;
              default: ;
            endcase
            if (hdr_cnt_r == 3'd5) begin
              idx_r <= 16'h0000;
              if (num_ops_r > MAX_OPS_W) begin
                state_r <= ST_DRAIN;
                drain_r <= 18'(num_ops_r) * 18'd3;
                err_r   <= 1'b1;
                if (!err_r) err_code_r <= ERR_LENGTH;
              end else if (num_ops_r == 16'h0000) begin
                state_r     <= ST_START;
                cmd_ready_r <= 1'b0;
              end else begin
                state_r <= ST_LD_IN;
              end
            end else begin
              hdr_cnt_r <= hdr_cnt_r + 3'd1;
            end
          end
        end
        ST_LD_IN, ST_LD_IDX, ST_LD_WT: begin
          if (accept_s) begin
            if (idx_r == num_ops_r - 16'd1) begin
              idx_r <= 16'h0000;
              if (state_r == ST_LD_IN) begin
                state_r <= ST_LD_IDX;
              end else if (state_r == ST_LD_IDX) begin
                state_r <= ST_LD_WT;
              end else begin
                state_r     <= ST_START;
                cmd_ready_r <= 1'b0;
              end
            end else begin
              idx_r <= idx_r + 16'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (accept_s) begin
            if (drain_r == 18'd1) begin
              state_r     <= ST_IDLE;
              cmd_ready_r <= 1'b0;
            end else begin
              drain_r <= drain_r - 18'd1;
            end
          end
        end
        ST_START: begin
          state_r <= ST_WAIT_LO;
          tmo_r   <= '0;
        end
        // One timeout counter spans both wait states; progress wins over expiry.
        ST_WAIT_LO: begin
          if (!ReadyForNextOp) begin
            state_r <= ST_WAIT_HI;
            tmo_r   <= tmo_r + TMO_W'(1);
          end else if (tmo_r >= TMO_LAST) begin
            state_r <= ST_IDLE;
            err_r   <= 1'b1;
            if (!err_r) err_code_r <= ERR_TIMEOUT;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        ST_WAIT_HI: begin
          if (ReadyForNextOp) begin
            state_r  <= ST_READ;
            rd_cnt_r <= '0;
          end else if (tmo_r >= TMO_LAST) begin
            state_r <= ST_IDLE;
            err_r   <= 1'b1;
            if (!err_r) err_code_r <= ERR_TIMEOUT;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        // Address reaches the bus one cycle into READ; sample READ_LAT later.
        ST_READ: begin
          if (rd_cnt_r == RD_LAST) begin
            res_data_r  <= OutputData;
            res_valid_r <= 1'b1;
            state_r     <= ST_RESULT;
          end else begin
            rd_cnt_r <= rd_cnt_r + RD_W'(1);
          end
        end
        ST_RESULT: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b0;
        end
      endcase
    end
  end

  neuro_bus_writer u_writer (
    .clk         (clk),
    .rst_n       (rst_n),
    .beat_valid  (beat_valid_s),
    .beat_we     (beat_we_s),
    .beat_addr   (beat_addr_s),
    .beat_data   (beat_data_s),
    .beat_sel    (beat_sel_s),
    .Address     (Address),
    .InputData   (InputData),
    .CacheSelect (CacheSelect),
    .WE          (WE)
  );

  assign cmd_ready      = cmd_ready_r;
  assign res_valid      = res_valid_r;
  assign res_data       = res_data_r;
  assign err            = err_r;
  assign err_code       = err_code_r;
  assign StartOperation = start_r;

endmodule

// File: tb/tb_neuro_host_sequencer.sv
// tb_neuro_host_sequencer
// Scoreboard bench: each job pushes its expected bus writes and result word
// into queues; independent monitors pop and compare as the DUT presents them.
// An engine model drops/raises ReadyForNextOp after StartOperation and
// returns read data one cycle after the address is presented.
module tb_neuro_host_sequencer;

  localparam int MAX_OPS  = 256;
  localparam int READ_LAT = 1;
  localparam int TIMEOUT  = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_data;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] InputData, Address, OutputData;
  logic [1:0]  CacheSelect;
  logic        WE, StartOperation, ReadyForNextOp;

  neuro_host_sequencer #(.MAX_OPS(MAX_OPS), .READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .err_code(err_code),
    .InputData(InputData), .Address(Address), .CacheSelect(CacheSelect), .WE(WE),
    .StartOperation(StartOperation), .ReadyForNextOp(ReadyForNextOp), .OutputData(OutputData)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  sel;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_res[$];
  logic [15:0] in_q[$], idx_q[$], wt_q[$];
  logic [15:0] hdr_addr [6] = '{16'h8000, 16'h8001, 16'h8002, 16'h8004, 16'h8003, 16'h8005};

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int writes_seen = 0, starts_seen = 0, results_seen = 0;
  int last_start_cyc = 0;
  int hold_left = 0;
  bit hang = 1'b0;
  logic [15:0] job_dest = 16'h0000, job_result = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic wr_t mk_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
    wr_t w;
    w.addr = a; w.data = d; w.sel = s;
    return w;
  endfunction

  // Bus write / start monitor
  initial begin : bus_mon
    wr_t w;
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (WE === 1'b1) begin
        writes_seen++;
        if (exp_wr.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL bus_write: got unexpected write addr=%h data=%h sel=%b, required none",
                   Address, InputData, CacheSelect);
        end else begin
          w = exp_wr.pop_front();
          check("bus_write", {30'd0, Address, InputData, CacheSelect}, {30'd0, w.addr, w.data, w.sel});
        end
      end
      if (StartOperation === 1'b1) begin
        starts_seen++;
        last_start_cyc = cyc;
        check("start_we_low", 64'(WE), 64'd0);
        check("start_one_cycle", 64'(prev_start), 64'd0);
      end
      prev_start = StartOperation;
    end
  end

  // Result monitor: stability under backpressure and value on handshake
  initial begin : res_mon
    logic        pend;
    logic [15:0] pend_data;
    pend = 1'b0; pend_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        if (pend) check("res_stable", 64'(res_data), 64'(pend_data));
        if (res_ready === 1'b1) begin
          results_seen++;
          pend = 1'b0;
          if (exp_res.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL res_data: got unexpected result %h, required none", res_data);
          end else begin
            check("res_data", 64'(res_data), 64'(exp_res.pop_front()));
          end
        end else begin
          pend = 1'b1;
          pend_data = res_data;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  // Engine completion model
  initial begin : engine
    int lat;
    ReadyForNextOp = 1'b1;
    forever begin
      @(negedge clk);
      if (StartOperation === 1'b1) begin
        @(posedge clk); #1 ReadyForNextOp = 1'b0;
        lat = $urandom_range(1, 6);
        repeat (lat) @(posedge clk);
        while (hang) @(posedge clk);
        #1 ReadyForNextOp = 1'b1;
      end
    end
  end

  // Engine read port: data for the address seen one cycle earlier
  initial begin : rd_port
    logic [15:0] addr_q;
    OutputData = 16'h0000;
    forever begin
      @(negedge clk);
      addr_q = Address;
      @(posedge clk);
      #1 OutputData = (addr_q == job_dest) ? job_result : (addr_q ^ 16'hDEAD);
    end
  end

  // Result consumer: optional forced hold, otherwise random ready
  initial begin : consumer
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (res_valid === 1'b1 && hold_left > 0) begin
        hold_left--;
        res_ready = 1'b0;
      end else begin
        res_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Called and returns at posedge+1
  task automatic send_word(input logic [15:0] w, input int gap);
    int budget;
    if ($urandom_range(0, 99) < gap) begin
      cmd_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    cmd_valid = 1'b1;
    cmd_data  = w;
    budget = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (cmd_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: word %h not accepted within 200 cycles, required acceptance", w);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    in_q.delete(); idx_q.delete(); wt_q.delete();
    for (int i = 0; i < n; i++) begin
      in_q.push_back(16'($urandom));
      idx_q.push_back(16'($urandom));
      wt_q.push_back(16'($urandom));
    end
  endtask

  task automatic run_job(input logic [15:0] in_off, input logic [15:0] idx_off,
                         input logic [15:0] wt_off, input logic [15:0] dest,
                         input logic [15:0] num, input logic [15:0] act,
                         input logic [15:0] res, input int gap, input int hold,
                         input bit hang_job);
    logic [15:0] words[$];
    int wr0, st0, rs0, budget;
    bit ok_len;
    wr0 = writes_seen; st0 = starts_seen; rs0 = results_seen;
    ok_len = (int'(num) <= MAX_OPS);
    words = '{in_off, idx_off, wt_off, dest, num, act};
    for (int k = 0; k < 6; k++) exp_wr.push_back(mk_wr(hdr_addr[k], words[k], 2'b00));
    if (ok_len) begin
      for (int i = 0; i < int'(num); i++) begin
        words.push_back(in_q[i]);
        exp_wr.push_back(mk_wr(in_off + 16'(i), in_q[i], 2'b00));
      end
      for (int i = 0; i < int'(num); i++) begin
        words.push_back(idx_q[i]);
        exp_wr.push_back(mk_wr(idx_off + 16'(i), idx_q[i], 2'b01));
      end
      for (int i = 0; i < int'(num); i++) begin
        words.push_back(wt_q[i]);
        exp_wr.push_back(mk_wr(wt_off + 16'(i), wt_q[i], 2'b10));
      end
    end else begin
      for (int i = 0; i < 3 * int'(num); i++) words.push_back(16'($urandom));
    end
    job_dest = dest; job_result = res; hold_left = hold; hang = hang_job;
    if (ok_len && !hang_job) exp_res.push_back(res);
    foreach (words[i]) send_word(words[i], gap);

    if (!ok_len) begin
      repeat (10) @(posedge clk); #1;
      check("len_err", 64'(err), 64'd1);
      check("len_err_code", 64'(err_code), 64'd1);
      check("len_idle_ready", 64'(cmd_ready), 64'd0);
      check("len_writes", 64'(writes_seen - wr0), 64'd6);
      check("len_no_start", 64'(starts_seen - st0), 64'd0);
    end else if (hang_job) begin
      budget = 0;
      while (err !== 1'b1 && budget < TIMEOUT + 500) begin
        @(negedge clk);
        budget++;
      end
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_window", 64'((cyc - last_start_cyc >= TIMEOUT - 1) && (cyc - last_start_cyc <= TIMEOUT + 1)), 64'd1);
      @(posedge clk); #1;
      check("tmo_err_code", 64'(err_code), 64'd2);
      check("tmo_idle", {62'd0, cmd_ready, res_valid}, 64'd0);
      check("tmo_start", 64'(starts_seen - st0), 64'd1);
      hang = 1'b0;
      repeat (20) @(posedge clk); #1;
      check("tmo_no_result", 64'(results_seen - rs0), 64'd0);
    end else begin
      budget = 0;
      while (results_seen < rs0 + 1 && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
      if (results_seen < rs0 + 1) begin
        n_checks++; n_fail++;
        $display("FAIL result_wait: got no result in 3000 cycles, required one");
      end
      @(posedge clk); #1;
      check("job_writes", 64'(writes_seen - wr0), 64'(6 + 3 * int'(num)));
      check("job_start", 64'(starts_seen - st0), 64'd1);
    end
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin : main
    logic [15:0] h[6];
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 16'h0000;
    repeat (3) @(posedge clk); #1;
    check("reset_outputs", {cmd_ready, res_valid, err, err_code, WE, StartOperation,
                            Address, InputData, CacheSelect}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference job
    in_q = '{16'h3C00, 16'h4000}; idx_q = '{16'h0000, 16'h0001}; wt_q = '{16'h3C00, 16'h4000};
    run_job(16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0, 16'h4500, 0, 0, 1'b0);
    check("ref_no_err", 64'(err), 64'd0);

    // Same job with random cmd_valid gaps and a 10-cycle result hold
    run_job(16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0, 16'h4500, 50, 10, 1'b0);

    // Empty job
    run_job(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'd0, 16'd1, 16'h1234, 0, 0, 1'b0);

    // Random jobs, one with offsets at the 16-bit wrap
    for (int j = 0; j < 6; j++) begin
      int n;
      n = $urandom_range(1, 8);
      fill_random(n);
      if (j == 2)
        run_job(16'hFFFE, 16'hFFFD, 16'hFFFF, 16'($urandom), 16'(n), 16'($urandom_range(0, 3)),
                16'($urandom), 30, 3, 1'b0);
      else
        run_job(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'(n),
                16'($urandom_range(0, 3)), 16'($urandom), 30, $urandom_range(0, 4), 1'b0);
    end

    // Engine never finishes
    fill_random(2);
    run_job(16'h0100, 16'h0200, 16'h0300, 16'h0005, 16'd2, 16'd0, 16'h7777, 0, 0, 1'b1);

    // Reset in the middle of the index load
    fill_random(4);
    h = '{16'h0040, 16'h0050, 16'h0060, 16'h0007, 16'd4, 16'd2};
    for (int k = 0; k < 6; k++) begin
      exp_wr.push_back(mk_wr(hdr_addr[k], h[k], 2'b00));
      send_word(h[k], 0);
    end
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back(mk_wr(h[0] + 16'(i), in_q[i], 2'b00));
      send_word(in_q[i], 0);
    end
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back(mk_wr(h[1] + 16'(i), idx_q[i], 2'b01));
      send_word(idx_q[i], 0);
    end
    rst_n = 1'b0;
    #1;
    check("midjob_reset_outputs", {cmd_ready, res_valid, err, err_code, WE, StartOperation,
                                   Address, InputData, CacheSelect}, 64'd0);
    exp_wr.delete();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_clears_err", {62'd0, err, 1'b0} | 64'(err_code), 64'd0);
    fill_random(5);
    run_job(16'h0040, 16'h0050, 16'h0060, 16'h0007, 16'd5, 16'd2, 16'hBEEF, 20, 2, 1'b0);

    // Length error, then a normal job
    run_job(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'(MAX_OPS + 1), 16'd0, 16'h0000, 0, 0, 1'b0);
    fill_random(3);
    run_job(16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, 16'd3, 16'd1, 16'h5A5A, 10, 1, 1'b0);
    check("err_sticky_code", 64'(err_code), 64'd1);
    check("res_queue_empty", 64'(exp_res.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
